// File: rtl/eth_tx_frame_buffer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | eth_tx_frame_buffer: ping-pong payload buffer feeding the RGMII TX FSM.    |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
module eth_tx_frame_buffer #(
  parameter int ADDR_WIDTH = 11,
  parameter int START_GAP  = 4
) (
  input  logic        i_eth_clk,
  input  logic        i_rst,
  input  logic [7:0]  i_s_data,
  input  logic        i_s_valid,
  input  logic        i_s_last,
  output logic        o_s_ready,
  input  logic [15:0] i_eth_mem_rd_addr,
  output logic [7:0]  o_eth_data_out_8b,
  output logic [15:0] o_eth_tx_size,
  output logic        o_eth_tx_start,
  input  logic        i_busy,
  output logic        o_frame_drop,
  output logic [1:0]  o_frames_pending
);

  localparam int c_depth = 2 ** ADDR_WIDTH;
  localparam int c_gap_w = (START_GAP > 1) ? $clog2(START_GAP) : 1;
  localparam logic [ADDR_WIDTH-1:0] c_last_idx = ADDR_WIDTH'(c_depth - 2);
  localparam logic [c_gap_w-1:0]    c_gap_last = c_gap_w'(START_GAP - 1);

  typedef enum logic [1:0] {R_IDLE, R_START, R_WAIT, R_GAP} rd_state_e;

  logic [7:0] mem [0:2*c_depth-1];
  logic [7:0] rd_data_q;

  rd_state_e                   state_q, state_d;
  logic                        wr_bank_q, wr_bank_d;
  logic                        rd_bank_q, rd_bank_d;
  logic [1:0]                  full_q, full_d;
  logic [1:0][ADDR_WIDTH-1:0]  len_q, len_d;
  logic [ADDR_WIDTH-1:0]       count_q, count_d;
  logic                        drain_q, drain_d;
  logic                        drop_q, drop_d;
  logic [1:0]                  pending_q, pending_d;
  logic [ADDR_WIDTH-1:0]       tx_size_q, tx_size_d;
  logic                        start_q, start_d;
  logic [c_gap_w-1:0]          gap_q, gap_d;
  logic                        rd_valid_q, rd_valid_d;

  logic                        s_accept;
  logic                        wr_en;
  logic                        commit;
  logic                        rel_bank;
  logic [ADDR_WIDTH-1:0]       rd_idx;

  // While draining an oversize frame the write bank is never committed, so
  // bytes are always sunk regardless of bank occupancy.
  assign o_s_ready = drain_q || !full_q[wr_bank_q];
  assign s_accept  = i_s_valid && o_s_ready;
  assign wr_en     = s_accept && !drain_q;
  assign rd_idx    = ADDR_WIDTH'(i_eth_mem_rd_addr - 16'd1);

  always_comb begin
    state_d    = state_q;
    wr_bank_d  = wr_bank_q;
    rd_bank_d  = rd_bank_q;
    full_d     = full_q;
    len_d      = len_q;
    count_d    = count_q;
    drain_d    = drain_q;
    drop_d     = 1'b0;
    pending_d  = pending_q;
    tx_size_d  = tx_size_q;
    start_d    = start_q;
    gap_d      = gap_q;
    commit     = 1'b0;
    rel_bank   = 1'b0;

    if (s_accept) begin
      if (drain_q) begin
        if (i_s_last) begin
          drain_d = 1'b0;
          drop_d  = 1'b1;
        end
      end else if (i_s_last) begin
        commit              = 1'b1;
        full_d[wr_bank_q]   = 1'b1;
        len_d[wr_bank_q]    = count_q + 1'b1;
        wr_bank_d           = ~wr_bank_q;
        count_d             = '0;
      end else if (count_q == c_last_idx) begin
        drain_d = 1'b1;
        count_d = '0;
      end else begin
        count_d = count_q + 1'b1;
      end
    end

    case (state_q)
      R_IDLE: begin
        if (full_q[rd_bank_q]) begin
          tx_size_d = len_q[rd_bank_q];
          start_d   = 1'b1;
          state_d   = R_START;
        end
      end
      R_START: begin
        if (i_busy) begin
          start_d = 1'b0;
          state_d = R_WAIT;
        end
      end
      R_WAIT: begin
        if (!i_busy) begin
          gap_d   = '0;
          state_d = R_GAP;
        end
      end
      R_GAP: begin
        if (gap_q == c_gap_last) begin
          rel_bank          = 1'b1;
          full_d[rd_bank_q] = 1'b0;
          rd_bank_d         = ~rd_bank_q;
          state_d           = R_IDLE;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      default: state_d = R_IDLE;
    endcase

    case ({commit, rel_bank})
      2'b10:   pending_d = pending_q + 2'd1;
      2'b01:   pending_d = pending_q - 2'd1;
      default: pending_d = pending_q;
    endcase

    // Address 0 and anything past the stored length read back as zero padding.
    rd_valid_d = (i_eth_mem_rd_addr != 16'd0) &&
                 (i_eth_mem_rd_addr <= 16'(len_q[rd_bank_q]));
  end

  always_ff @(posedge i_eth_clk) begin
    if (i_rst) begin
      state_q    <= R_IDLE;
      wr_bank_q  <= 1'b0;
      rd_bank_q  <= 1'b0;
      full_q     <= '0;
      len_q      <= '0;
      count_q    <= '0;
      drain_q    <= 1'b0;
      drop_q     <= 1'b0;
      pending_q  <= '0;
      tx_size_q  <= '0;
      start_q    <= 1'b0;
      gap_q      <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_bank_q  <= wr_bank_d;
      rd_bank_q  <= rd_bank_d;
      full_q     <= full_d;
      len_q      <= len_d;
      count_q    <= count_d;
      drain_q    <= drain_d;
      drop_q     <= drop_d;
      pending_q  <= pending_d;
      tx_size_q  <= tx_size_d;
      start_q    <= start_d;
      gap_q      <= gap_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  always_ff @(posedge i_eth_clk) begin
    if (wr_en) begin
      mem[{wr_bank_q, count_q}] <= i_s_data;
    end
    rd_data_q <= mem[{rd_bank_q, rd_idx}];
  end

  assign o_eth_data_out_8b = rd_valid_q ? rd_data_q : 8'h00;
  assign o_eth_tx_size     = 16'(tx_size_q);
  assign o_eth_tx_start    = start_q;
  assign o_frame_drop      = drop_q;
  assign o_frames_pending  = pending_q;

endmodule
`default_nettype wire
